uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the 50 MHz core domain, the successor to the fixed 8N1 receiver. It adds configurable frame format (5–9 data bits, none/odd/even parity, 1 or 2 stop bits), an input synchroniser and false-start rejection. Each received frame is flagged for parity, framing and overrun errors and buffered in a ready/valid receive FIFO. It feeds the boot loader / memory-programming path, which consumes bytes at its own pace.

Parameters:
CLK_FREQ_HZ, 50_000_000, core clock frequency.
BAUD, 57600, line rate; BAUD_DIV = CLK_FREQ_HZ/BAUD (truncating), HALF_DIV = BAUD_DIV/2.
DATA_BITS, 8, data bits per frame, legal 5..9.
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, legal 1 or 2.
FIFO_DEPTH, 8, receive FIFO entries, power of two, at least 2.

Ports:
clk  input  1  core clock, all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
io_rx  input  1  serial line, idle high, asynchronous to clk.
io_data_ready  input  1  consumer pops the head entry when asserted with io_data_valid.
io_clear_overrun  input  1  clears the sticky overrun flag.
io_data_valid  output  1  FIFO not empty.
io_data_packet  output  DATA_BITS  head-entry data, LSB = first bit received.
io_parity_err  output  1  head-entry parity error; 0 when PARITY_MODE = 0.
io_framing_err  output  1  head-entry framing error (any stop bit sampled 0).
io_overrun  output  1  sticky: a frame completed while the FIFO was full.
io_fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous assert, release on clk): state IDLE, counters 0, FIFO empty, synchroniser flops = 1. All outputs 0.
- io_rx passes through a 2-flop synchroniser (rx_s) before any use; 2-cycle detection latency.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. A single baud counter cnt is cleared on every state entry.
- IDLE: rx_s == 0 -> START.
- START: when cnt == HALF_DIV-1, sample rx_s.
  - 0 -> DATA.
  - 1 -> IDLE; the glitch is discarded and no FIFO write occurs.
- DATA: each time cnt == BAUD_DIV-1, sample rx_s into shift register, LSB first, and reset cnt. After DATA_BITS samples: -> PARITY if PARITY_MODE != 0, else -> STOP.
- PARITY: sample at cnt == BAUD_DIV-1.
  - Odd mode: perr = ~(^{data, p}).
  - Even mode: perr = ^{data, p}.
- STOP: sample STOP_BITS times at BAUD_DIV intervals; ferr = OR of (sample == 0).
  - On the last stop sample, the frame is pushed (see FIFO rules) in the same cycle.
  - Next state: -> IDLE if the last sample was 1, else -> WAIT_IDLE.
- WAIT_IDLE (break / framing): stay until rx_s == 1, then -> IDLE. A held-low line never produces more than one frame.
- FIFO entry = {ferr, perr, data}.
  - Push not full: entry written; io_data_valid rises on the cycle after the push.
  - Push when full and no pop in the same cycle: frame dropped, io_overrun set on the next cycle.
  - Simultaneous push and pop when full: both succeed, no overrun.
  - Pop when empty: ignored.
  - First-word fall-through: io_data_packet and the flags are valid whenever io_data_valid = 1, and stable until popped.
- io_overrun stays set until io_clear_overrun. If set and clear coincide, set wins.
- Read and write pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally; full is defined as MSBs differ and lower bits equal.
- Reset mid-frame: the partial frame is discarded and the FIFO is emptied.

Decomposition:
- uart_pkg holds:
  - rx_state_t enum;
  - parity_mode_t enum (PAR_NONE, PAR_ODD, PAR_EVEN);
  - localparam function baud_div(freq, baud).
- Elaboration assertions on the parameter ranges.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count). It is reused later by the TX path.

Test Plan:
- 8N1, BAUD_DIV = 868: send 0xA5, then 0x3C, ready held 0 -> count = 2, head 0xA5 with no error flags. Pop -> head 0x3C.
- PARITY_MODE = 2: send 0x07 with parity bit 1 -> perr = 0. Send 0x07 with parity bit 0 -> perr = 1, data still 0x07.
- Low glitch of 300 cycles (< HALF_DIV = 434) on idle line -> no push, FSM back in IDLE, count stays 0.
- Stop bit driven 0 followed by line low for 5 bit times (break) -> exactly one entry, data 0x00, ferr = 1. The next frame sent after line recovery is received cleanly.
- FIFO_DEPTH = 4: send 5 frames with ready = 0 -> count = 4, io_overrun = 1, first 4 bytes intact. io_clear_overrun -> 0. Repeat with a pop coinciding with the 5th push -> no overrun.
- Assert reset_n = 0 mid-DATA of a frame with 2 entries queued -> io_data_valid = 0 and count = 0 immediately (asynchronous). After release, a new frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path (and later the TX path).
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_IDLE = 3'd5
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_mode_t;

  // Clock cycles per bit, truncating.
  function automatic int baud_div(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with extended-pointer full/empty detection.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             pushEn;
  logic             popEn;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign popEn   = pop_i && !empty_o;
  // A push into a full FIFO only succeeds when a pop frees the slot in the same cycle.
  assign pushEn  = push_i && (!full_o || popEn);
  assign count_o = wrPtr_q - rdPtr_q;
  assign data_o  = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

  // Advance the pointers on accepted push/pop.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (pushEn) wrPtr_d = wrPtr_q + PTR_ONE;
    if (popEn)  rdPtr_d = rdPtr_q + PTR_ONE;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage array; contents need no reset because the output is masked when empty.
  always_ff @(posedge clk) begin
    if (pushEn) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with synchroniser, false-start rejection, error flags and receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 57600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          io_rx,
  input  logic                          io_data_ready,
  input  logic                          io_clear_overrun,
  output logic                          io_data_valid,
  output logic [DATA_BITS-1:0]          io_data_packet,
  output logic                          io_parity_err,
  output logic                          io_framing_err,
  output logic                          io_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   io_fifo_count
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ_HZ, BAUD);
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int EW       = DATA_BITS + 2;

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam parity_mode_t  PMODE     = parity_mode_t'(PARITY_MODE);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
    $error("uart_rx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : gBadParity
    $error("uart_rx_fifo: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
    $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
  end
  if (BAUD_DIV < 2) begin : gBadBaud
    $error("uart_rx_fifo: CLK_FREQ_HZ/BAUD must be at least 2");
  end

  rx_state_t              state_q, state_d;
  logic [1:0]             rxSync_q;
  logic                   rxS;
  logic [CW-1:0]          baudCnt_q, baudCnt_d;
  logic [3:0]             bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parErr_q, parErr_d;
  logic                   frmErr_q, frmErr_d;
  logic                   overrun_q;
  logic                   fifoPush;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [EW-1:0]          fifoEntry;
  logic [EW-1:0]          fifoHead;

  assign rxS = rxSync_q[1];

  // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rxSync_q <= 2'b11;
    else          rxSync_q <= {rxSync_q[0], io_rx};
  end

  // Entry captured at the last stop sample; the current sample folds into the framing flag.
  assign fifoEntry = {frmErr_q | ~rxS, parErr_q, shift_q};

  // Receiver next-state logic: baud counter restarts on every state entry and every sample.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q + CNT_ONE;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    parErr_d  = parErr_q;
    frmErr_d  = frmErr_q;
    fifoPush  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        baudCnt_d = '0;
        if (!rxS) begin
          state_d  = RX_START;
          bitCnt_d = '0;
          parErr_d = 1'b0;
          frmErr_d = 1'b0;
        end
      end
      RX_START: begin
        if (baudCnt_q == HALF_LAST) begin
          baudCnt_d = '0;
          state_d   = rxS ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baudCnt_q == BAUD_LAST) begin
          baudCnt_d = '0;
          shift_d   = {rxS, shift_q[DATA_BITS-1:1]};
          if (bitCnt_q == DATA_LAST) begin
            bitCnt_d = '0;
            state_d  = (PMODE != PAR_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (baudCnt_q == BAUD_LAST) begin
          baudCnt_d = '0;
          if (PMODE == PAR_ODD) parErr_d = ~(^{shift_q, rxS});
          else                  parErr_d = ^{shift_q, rxS};
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (baudCnt_q == BAUD_LAST) begin
          baudCnt_d = '0;
          frmErr_d  = frmErr_q | ~rxS;
          if (bitCnt_q == STOP_LAST) begin
            bitCnt_d = '0;
            fifoPush = 1'b1;
            state_d  = rxS ? RX_IDLE : RX_WAIT_IDLE;
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end
      RX_WAIT_IDLE: begin
        baudCnt_d = '0;
        if (rxS) state_d = RX_IDLE;
      end
      default: begin
        baudCnt_d = '0;
        state_d   = RX_IDLE;
      end
    endcase
  end

  // Receiver state registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RX_IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      parErr_q  <= 1'b0;
      frmErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      parErr_q  <= parErr_d;
      frmErr_q  <= frmErr_d;
    end
  end

  // Sticky overrun: a frame lost to a full FIFO with no pop; setting beats clearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    overrun_q <= 1'b0;
    else if (fifoPush && fifoFull && !io_data_ready) overrun_q <= 1'b1;
    else if (io_clear_overrun)                       overrun_q <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifoPush),
    .data_i  (fifoEntry),
    .pop_i   (io_data_ready),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (io_fifo_count)
  );

  assign io_data_valid  = ~fifoEmpty;
  assign io_data_packet = fifoHead[DATA_BITS-1:0];
  assign io_parity_err  = fifoHead[DATA_BITS];
  assign io_framing_err = fifoHead[DATA_BITS+1];
  assign io_overrun     = overrun_q;

endmodule
